// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-edge bit shifting and ACK check.
// Drives open-collector enables only (oe=1 pulls the line low).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  // state      | meaning
  // IDLE       | lines released, ready for a command
  // INHIBIT    | clock held low by the host
  // RTS        | clock and data low for one cycle (start bit)
  // WAIT_FIRST | clock released, waiting for the device's first falling edge
  // BITS       | shifting data, parity, stop on device falling edges
  // WAIT_IDLE  | ACK seen, waiting for both lines to return high
  // ERR        | timeout or missing ACK, one-cycle error pulse
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_FIRST, S_BITS, S_WAIT_IDLE, S_ERR
  } state_t;

  localparam logic [19:0] L_INH_LOAD   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] L_START_LOAD = 20'(START_TIMEOUT);
  localparam logic [19:0] L_BIT_LOAD   = 20'(BIT_TIMEOUT - 1);

  state_t      r_state;
  logic [19:0] r_cnt;
  logic [3:0]  r_n;
  logic [7:0]  r_sh;
  logic        r_par;
  logic        r_clk_meta, r_clk_sync, r_clk_prev;
  logic        r_dat_meta, r_dat_sync;

  state_t      w_state_nxt;
  logic [19:0] w_cnt_nxt;
  logic [3:0]  w_n_nxt;
  logic        w_accept;
  logic        w_fe;
  logic        w_tc;
  logic [2:0]  w_bit_idx;
  logic        w_bit_oe;
  logic        w_clk_oe, w_dat_oe, w_done, w_err, w_ready;

  assign w_fe      = r_clk_prev & ~r_clk_sync;
  assign w_tc      = (r_cnt == 20'd0);
  assign w_accept  = (r_state == S_IDLE) & cmd_valid;
  assign w_bit_idx = 3'(r_n - 4'd1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_sh       <= '0;
      r_par      <= 1'b0;
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_n        <= w_n_nxt;
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_dat_in;
      r_dat_sync <= r_dat_meta;
      if (w_accept) begin
        r_sh  <= cmd_data;
        r_par <= ~^cmd_data;
      end
    end
  end

  // Edge count n selects the frame bit: 1..8 data LSB first, 9 parity, 10 stop (released).
  always_comb begin
    w_bit_oe = 1'b0;
    if (r_n >= 4'd1 && r_n <= 4'd8) begin
      w_bit_oe = ~r_sh[w_bit_idx];
    end else if (r_n == 4'd9) begin
      w_bit_oe = ~r_par;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    w_clk_oe    = 1'b0;
    w_dat_oe    = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = S_INHIBIT;
          w_cnt_nxt   = L_INH_LOAD;
        end
      end
      S_INHIBIT: begin
        w_clk_oe = 1'b1;
        if (w_tc) w_state_nxt = S_RTS;
        else      w_cnt_nxt   = r_cnt - 20'd1;
      end
      S_RTS: begin
        w_clk_oe    = 1'b1;
        w_dat_oe    = 1'b1;
        w_state_nxt = S_WAIT_FIRST;
        w_cnt_nxt   = L_START_LOAD;
      end
      S_WAIT_FIRST: begin
        w_dat_oe = 1'b1;
        // A device edge coinciding with the terminal count still counts.
        if (w_fe) begin
          w_state_nxt = S_BITS;
          w_n_nxt     = 4'd1;
          w_cnt_nxt   = L_BIT_LOAD;
        end else if (w_tc) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt - 20'd1;
        end
      end
      S_BITS: begin
        w_dat_oe = w_bit_oe;
        if (w_fe) begin
          w_cnt_nxt = L_BIT_LOAD;
          if (r_n == 4'd10) w_state_nxt = r_dat_sync ? S_ERR : S_WAIT_IDLE;
          else              w_n_nxt     = r_n + 4'd1;
        end else if (w_tc) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt - 20'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (r_clk_sync && r_dat_sync) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tc) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt - 20'd1;
        end
      end
      S_ERR: begin
        w_err       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready  = w_ready;
  assign busy       = ~w_ready;
  assign ps2_clk_oe = w_clk_oe;
  assign ps2_dat_oe = w_dat_oe;
  assign tx_done    = w_done;
  assign tx_error   = w_err;

endmodule
